uart_rx_param: RTL and testbench

Parametrised UART receiver. It is the successor to the fixed 8N1 receiver and keeps the same req/ack consumer handshake. It adds configurable data width, oversampling ratio and stop-bit count, mid-bit sampling with false-start rejection, and a one-word holding register. It also reports framing and overrun errors. It sits between the serial pin and the byte consumer (command decoder / FIFO).

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_rx_sync.sv | 36 +++
 rtl/uart_rx_param.sv | 224 ++++++++++++++++++++++
 tb/tb_uart_rx_param.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the parametrised UART receiver.
//   uart_rx_state_t : receiver FSM states
//   clog2           : ceiling log2 (minimum 1), sizes the counters
//   UART_IDLE_LEVEL : level of the serial line when idle
package uart_pkg;

  localparam logic UART_IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } uart_rx_state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: SYNC_STAGES-deep flop chain that brings the asynchronous
// serial input into the clk domain.  Every flop resets to the line idle level
// so that a reset never looks like a start bit.
// Ports:
//   clk   - system clock
//   clr   - synchronous active-high reset
//   rcv   - asynchronous serial input
//   rcv_s - synchronised serial input (last flop of the chain)
module uart_rx_sync
  import uart_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic clr,
  input  logic rcv,
  output logic rcv_s
);

  logic [SYNC_STAGES-1:0] stage_reg;

  for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
    always_ff @(posedge clk) begin
      if (clr) begin
        stage_reg[gi] <= UART_IDLE_LEVEL;
      end else if (gi == 0) begin
        stage_reg[gi] <= rcv;
      end else begin
        stage_reg[gi] <= stage_reg[(gi == 0) ? 0 : gi-1];
      end
    end
  end

  assign rcv_s = stage_reg[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver with req/ack consumer handshake,
// mid-bit sampling, false-start rejection, one-word holding register and
// framing / overrun reporting.
// Optional feature macro: UART_RX_PARITY_EN (adds PARITY_ODD parameter,
// a parity bit after the data bits and the parity_err output).
// Ports:
//   clk        - system clock, rising edge
//   clr        - synchronous active-high reset
//   rcv        - asynchronous serial input, idles high
//   ack        - consumer acknowledge for req
//   req        - data word valid, held until ack
//   data       - received word, stable while req=1
//   frame_err  - word in data had a low stop bit
//   overrun    - sticky: a frame was lost while req=1, cleared by ack
//   busy       - FSM not in IDLE
//   parity_err - (macro only) parity mismatch for the word in data
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1,
  parameter int SYNC_STAGES  = 2
`ifdef UART_RX_PARITY_EN
  ,
  parameter int PARITY_ODD   = 0
`endif
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 rcv,
  input  logic                 ack,
  output logic                 req,
  output logic [DATA_BITS-1:0] data,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
`ifdef UART_RX_PARITY_EN
  ,
  output logic                 parity_err
`endif
);

  localparam int CW = clog2(CLKS_PER_BIT);
  localparam int BW = clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT/2 - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
`ifdef UART_RX_PARITY_EN
  localparam logic PAR_ODD_BIT = PARITY_ODD[0];
  localparam uart_rx_state_t AFTER_DATA = PARITY;
`else
  localparam uart_rx_state_t AFTER_DATA = STOP;
`endif

  logic rcv_s;

  uart_rx_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .clr  (clr),
    .rcv  (rcv),
    .rcv_s(rcv_s)
  );

  uart_rx_state_t       state_reg, state_next;
  logic [CW-1:0]        cnt_reg, cnt_next;
  logic [BW-1:0]        bit_reg, bit_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic                 ferr_reg, ferr_next;
  logic                 done_reg, done_next;
  logic                 req_reg;
  logic [DATA_BITS-1:0] data_reg;
  logic                 frame_err_reg;
  logic                 overrun_reg;
`ifdef UART_RX_PARITY_EN
  logic                 perr_reg, perr_next;
  logic                 parity_err_reg;
`endif

  always_ff @(posedge clk) begin
    if (clr) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
      ferr_reg  <= 1'b0;
      done_reg  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_reg  <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
      ferr_reg  <= ferr_next;
      done_reg  <= done_next;
`ifdef UART_RX_PARITY_EN
      perr_reg  <= perr_next;
`endif
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    ferr_next  = ferr_reg;
    done_next  = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_next  = perr_reg;
`endif
    case (state_reg)
      IDLE: begin
        cnt_next  = '0;
        bit_next  = '0;
        ferr_next = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_next = 1'b0;
`endif
        if (rcv_s != UART_IDLE_LEVEL) state_next = START;
      end
      START: begin
        // Re-check the line half a bit in: a glitch shorter than that is
        // not a start bit.
        if (cnt_reg == HALF_LAST) begin
          cnt_next   = '0;
          state_next = (rcv_s == UART_IDLE_LEVEL) ? IDLE : DATA;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      DATA: begin
        if (cnt_reg == CNT_LAST) begin
          cnt_next   = '0;
          // LSB arrives first, so shift in from the top.
          shift_next = {rcv_s, shift_reg[DATA_BITS-1:1]};
          if (bit_reg == DATA_LAST) begin
            bit_next   = '0;
            state_next = AFTER_DATA;
          end else begin
            bit_next = bit_reg + BW'(1);
          end
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_reg == CNT_LAST) begin
          cnt_next   = '0;
          perr_next  = (^{shift_reg, rcv_s}) != PAR_ODD_BIT;
          state_next = STOP;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
`endif
      STOP: begin
        if (cnt_reg == CNT_LAST) begin
          cnt_next = '0;
          if (rcv_s != UART_IDLE_LEVEL) ferr_next = 1'b1;
          if (bit_reg == STOP_LAST) begin
            bit_next   = '0;
            done_next  = 1'b1;
            // A line still low after the last stop bit is a break: do not
            // treat it as the next start bit.
            state_next = (rcv_s == UART_IDLE_LEVEL) ? IDLE : BREAK;
          end else begin
            bit_next = bit_reg + BW'(1);
          end
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      BREAK: begin
        if (rcv_s == UART_IDLE_LEVEL) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Holding register and handshake.  done_reg pulses the cycle after the
  // last stop sample; an ack in that same cycle frees the slot for the new
  // word, otherwise a pending word wins and the new one is counted as lost.
  always_ff @(posedge clk) begin
    if (clr) begin
      req_reg        <= 1'b0;
      data_reg       <= '0;
      frame_err_reg  <= 1'b0;
      overrun_reg    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_reg <= 1'b0;
`endif
    end else if (done_reg && (!req_reg || ack)) begin
      req_reg        <= 1'b1;
      data_reg       <= shift_reg;
      frame_err_reg  <= ferr_reg;
      overrun_reg    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_reg <= perr_reg;
`endif
    end else if (done_reg) begin
      overrun_reg <= 1'b1;
    end else if (req_reg && ack) begin
      req_reg     <= 1'b0;
      overrun_reg <= 1'b0;
    end
  end

  assign req       = req_reg;
  assign data      = data_reg;
  assign frame_err = frame_err_reg;
  assign overrun   = overrun_reg;
  assign busy      = (state_reg != IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_reg;
`endif

endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: scoreboard bench for uart_rx_param.
// Instance A uses the defaults (8 data bits, 1 stop bit); instance B uses
// 7 data bits and 2 stop bits.  The frame driver pushes the expected word
// and its delivery cycle; a negedge monitor pops on every delivery.
module tb_uart_rx_param;

  localparam int CLKS = 16;
`ifdef UART_RX_PARITY_EN
  localparam bit HAS_PAR = 1'b1;
  localparam int LAT_A = 171;  // 2 + 16*(8+1+1) + 8 + 1
  localparam int LAT_B = 171;  // 2 + 16*(7+1+2) + 8 + 1
`else
  localparam bit HAS_PAR = 1'b0;
  localparam int LAT_A = 155;  // 2 + 16*(8+1) + 8 + 1
  localparam int LAT_B = 155;  // 2 + 16*(7+2) + 8 + 1
`endif

  typedef struct {
    logic [8:0] data;
    logic       fe;
    logic       pe;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       rcv_a = 1'b1, rcv_b = 1'b1;
  logic       ack_a = 1'b0, ack_b = 1'b0;
  logic       req_a, req_b;
  logic [7:0] data_a;
  logic [6:0] data_b;
  logic       frame_err_a, frame_err_b, overrun_a, overrun_b, busy_a, busy_b;
`ifdef UART_RX_PARITY_EN
  logic       parity_err_a, parity_err_b;
`endif

  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  int   last_start = 0;
  int   frames_started = 0;
  exp_t qa[$];
  exp_t qb[$];

  logic       req_a_prev = 1'b0, req_b_prev = 1'b0;
  logic [7:0] data_a_prev = '0;
  logic [6:0] data_b_prev = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_param u_dut_a (
    .clk       (clk),
    .clr       (clr),
    .rcv       (rcv_a),
    .ack       (ack_a),
    .req       (req_a),
    .data      (data_a),
    .frame_err (frame_err_a),
    .overrun   (overrun_a),
    .busy      (busy_a)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err(parity_err_a)
`endif
  );

  uart_rx_param #(
    .DATA_BITS   (7),
    .CLKS_PER_BIT(16),
    .STOP_BITS   (2),
    .SYNC_STAGES (2)
`ifdef UART_RX_PARITY_EN
    ,
    .PARITY_ODD  (0)
`endif
  ) u_dut_b (
    .clk       (clk),
    .clr       (clr),
    .rcv       (rcv_b),
    .ack       (ack_b),
    .req       (req_b),
    .data      (data_b),
    .frame_err (frame_err_b),
    .overrun   (overrun_b),
    .busy      (busy_b)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err(parity_err_b)
`endif
  );

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endfunction

  // Monitor: a delivery is req rising, or a new word replacing the held one.
  always @(negedge clk) begin
    if (!clr) begin
      if (req_a && (!req_a_prev || data_a !== data_a_prev)) begin
        if (qa.size() == 0) begin
          chk("a_unexpected_word", {24'd0, data_a}, 32'hFFFF_FFFF);
        end else begin
          $display("[TB] A word %02h frame_err=%0b at cycle %0d", data_a, frame_err_a, cyc);
          chk("a_data", {24'd0, data_a}, {23'd0, qa[0].data});
          chk("a_frame_err", {31'd0, frame_err_a}, {31'd0, qa[0].fe});
          chk("a_latency", cyc, qa[0].cyc);
`ifdef UART_RX_PARITY_EN
          chk("a_parity_err", {31'd0, parity_err_a}, {31'd0, qa[0].pe});
`endif
          void'(qa.pop_front());
        end
      end
      if (req_b && (!req_b_prev || data_b !== data_b_prev)) begin
        if (qb.size() == 0) begin
          chk("b_unexpected_word", {25'd0, data_b}, 32'hFFFF_FFFF);
        end else begin
          $display("[TB] B word %02h frame_err=%0b at cycle %0d", data_b, frame_err_b, cyc);
          chk("b_data", {25'd0, data_b}, {23'd0, qb[0].data});
          chk("b_frame_err", {31'd0, frame_err_b}, {31'd0, qb[0].fe});
          chk("b_latency", cyc, qb[0].cyc);
`ifdef UART_RX_PARITY_EN
          chk("b_parity_err", {31'd0, parity_err_b}, {31'd0, qb[0].pe});
`endif
          void'(qb.pop_front());
        end
      end
    end
    req_a_prev  <= req_a;
    req_b_prev  <= req_b;
    data_a_prev <= data_a;
    data_b_prev <= data_b;
  end

  // inst 0 = A (8 data, 1 stop), 1 = B (7 data, 2 stop).  stops[0] is sent
  // first.  With parity the bit is even parity, inverted when par_flip=1.
  task automatic send_frame(input bit inst, input logic [8:0] d, input bit par_flip,
                            input logic [1:0] stops, input bit expect_word, input logic exp_fe);
    logic [15:0] bits;
    int          n;
    int          nd;
    int          ns;
    logic        par;
    exp_t        e;
    nd = inst ? 7 : 8;
    ns = inst ? 2 : 1;
    bits = '1;
    bits[0] = 1'b0;
    par = par_flip;
    for (int i = 0; i < nd; i++) begin
      bits[1+i] = d[i];
      par = par ^ d[i];
    end
    n = 1 + nd;
    if (HAS_PAR) begin
      bits[n] = par;
      n++;
    end
    for (int i = 0; i < ns; i++) begin
      bits[n] = stops[i];
      n++;
    end
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (inst) rcv_b = bits[i];
      else      rcv_a = bits[i];
      if (i == 0) begin
        last_start = cyc + 1;
        frames_started++;
        if (expect_word) begin
          e.data = d;
          e.fe   = exp_fe;
          e.pe   = par_flip;
          e.cyc  = cyc + 1 + (inst ? LAT_B : LAT_A);
          if (inst) qb.push_back(e);
          else      qa.push_back(e);
        end
      end
      repeat (CLKS - 1) @(posedge clk);
    end
  endtask

  task automatic wait_req(input bit inst, input int bound);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < bound && !seen; i++) begin
      if (inst ? req_b : req_a) seen = 1'b1;
      else @(negedge clk);
    end
    if (!seen) chk(inst ? "b_req_timeout" : "a_req_timeout", 32'd0, 32'd1);
  endtask

  task automatic ack_pulse(input bit inst);
    @(posedge clk);
    #1;
    if (inst) ack_b = 1'b1;
    else      ack_a = 1'b1;
    @(posedge clk);
    #1;
    ack_a = 1'b0;
    ack_b = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int target;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_a", {31'd0, req_a}, 32'd0);
    chk("rst_data_a", {24'd0, data_a}, 32'd0);
    chk("rst_frame_err_a", {31'd0, frame_err_a}, 32'd0);
    chk("rst_overrun_a", {31'd0, overrun_a}, 32'd0);
    chk("rst_busy_a", {31'd0, busy_a}, 32'd0);
    chk("rst_req_b", {31'd0, req_b}, 32'd0);
    clr = 1'b0;
    repeat (5) @(posedge clk);

    // 0xA5, ack three cycles after req
    send_frame(1'b0, 9'h0A5, 1'b0, 2'b11, 1'b1, 1'b0);
    wait_req(1'b0, 400);
    repeat (3) @(posedge clk);
    #1;
    chk("a5_req_held", {31'd0, req_a}, 32'd1);
    ack_pulse(1'b0);
    chk("a5_req_fall", {31'd0, req_a}, 32'd0);
    repeat (10) @(posedge clk);

    // False start: low for 5 cycles only
    @(posedge clk);
    #1;
    rcv_a = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rcv_a = 1'b1;
    chk("fs_busy_start", {31'd0, busy_a}, 32'd1);
    repeat (7) @(posedge clk);
    #1;
    chk("fs_busy_idle", {31'd0, busy_a}, 32'd0);
    repeat (30) @(posedge clk);
    #1;
    chk("fs_no_req", {31'd0, req_a}, 32'd0);

    // 0x3C with low stop bit, then line held low (break)
    send_frame(1'b0, 9'h03C, 1'b0, 2'b00, 1'b1, 1'b1);
    wait_req(1'b0, 100);
    ack_pulse(1'b0);
    chk("fe_ack_req", {31'd0, req_a}, 32'd0);
    repeat (30) @(posedge clk);
    #1;
    chk("brk_busy", {31'd0, busy_a}, 32'd1);
    chk("brk_no_req", {31'd0, req_a}, 32'd0);
    rcv_a = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("brk_exit", {31'd0, busy_a}, 32'd0);
    repeat (10) @(posedge clk);

    // Overrun: 0x11 then 0x22 back-to-back, no ack
    send_frame(1'b0, 9'h011, 1'b0, 2'b11, 1'b1, 1'b0);
    send_frame(1'b0, 9'h022, 1'b0, 2'b11, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    chk("ovr_data", {24'd0, data_a}, 32'h11);
    chk("ovr_flag", {31'd0, overrun_a}, 32'd1);
    chk("ovr_req", {31'd0, req_a}, 32'd1);
    ack_pulse(1'b0);
    chk("ovr_ack_req", {31'd0, req_a}, 32'd0);
    chk("ovr_ack_clear", {31'd0, overrun_a}, 32'd0);
    repeat (20) @(posedge clk);

    // Ack exactly on the second delivery cycle
    base = frames_started;
    fork
      begin
        send_frame(1'b0, 9'h011, 1'b0, 2'b11, 1'b1, 1'b0);
        send_frame(1'b0, 9'h022, 1'b0, 2'b11, 1'b1, 1'b0);
      end
    join_none
    for (int i = 0; i < 1000 && frames_started < base + 2; i++) begin
      @(posedge clk);
      #1;
    end
    target = last_start + LAT_A - 1;
    for (int i = 0; i < 400 && cyc < target; i++) begin
      @(posedge clk);
      #1;
    end
    ack_a = 1'b1;
    @(posedge clk);
    #1;
    ack_a = 1'b0;
    chk("ackdel_req", {31'd0, req_a}, 32'd1);
    chk("ackdel_data", {24'd0, data_a}, 32'h22);
    chk("ackdel_overrun", {31'd0, overrun_a}, 32'd0);
    repeat (10) @(posedge clk);
    ack_pulse(1'b0);
    chk("ackdel_clear", {31'd0, req_a}, 32'd0);
    repeat (10) @(posedge clk);

    // Instance B: 0x55, 7 data bits, 2 stop bits (wrong parity when enabled)
    send_frame(1'b1, 9'h055, 1'b1, 2'b11, 1'b1, 1'b0);
    wait_req(1'b1, 100);
    ack_pulse(1'b1);
    chk("b_ack_req", {31'd0, req_b}, 32'd0);
    repeat (10) @(posedge clk);
    // Second stop bit low must still flag a framing error
    send_frame(1'b1, 9'h055, 1'b0, 2'b01, 1'b1, 1'b1);
    #1;
    rcv_b = 1'b1;
    wait_req(1'b1, 100);
    repeat (10) @(posedge clk);

    // clr mid-frame on A while B still holds a word
    fork
      send_frame(1'b0, 9'h0E0, 1'b0, 2'b11, 1'b0, 1'b0);
    join_none
    repeat (101) @(posedge clk);
    #1;
    chk("clr_pre_busy_a", {31'd0, busy_a}, 32'd1);
    chk("clr_pre_req_b", {31'd0, req_b}, 32'd1);
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    chk("clr_busy_a", {31'd0, busy_a}, 32'd0);
    chk("clr_req_a", {31'd0, req_a}, 32'd0);
    chk("clr_data_a", {24'd0, data_a}, 32'd0);
    chk("clr_req_b", {31'd0, req_b}, 32'd0);
    chk("clr_data_b", {25'd0, data_b}, 32'd0);
    chk("clr_frame_err_b", {31'd0, frame_err_b}, 32'd0);
    chk("clr_overrun_b", {31'd0, overrun_b}, 32'd0);
`ifdef UART_RX_PARITY_EN
    chk("clr_parity_err_b", {31'd0, parity_err_b}, 32'd0);
`endif
    repeat (120) @(posedge clk);
    #1;
    chk("clr_no_resume_busy", {31'd0, busy_a}, 32'd0);
    chk("clr_no_resume_req", {31'd0, req_a}, 32'd0);

    chk("qa_drained", qa.size(), 32'd0);
    chk("qb_drained", qb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
